// File: rtl/rf_wb_arbiter.sv
// Two-source writeback arbiter for the integer register-file write port, x0 writes squashed.
// Latency: accepted in cycle N, WE3/A3/WD3 presented in cycle N+1; one write per cycle.
// Backpressure: requester 0 wins by default; requester 1 is force-granted after STARVE_MAX losses.
module rf_wb_arbiter #(
    parameter int XLEN       = 32,
    parameter int AW         = 5,
    parameter int STARVE_MAX = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wb0_valid,
    input  logic [AW-1:0]   wb0_addr,
    input  logic [XLEN-1:0] wb0_data,
    output logic            wb0_ready,
    input  logic            wb1_valid,
    input  logic [AW-1:0]   wb1_addr,
    input  logic [XLEN-1:0] wb1_data,
    output logic            wb1_ready,
    output logic            WE3,
    output logic [AW-1:0]   A3,
    output logic [XLEN-1:0] WD3,
    output logic            wb_src
);

    localparam int SCW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SCW-1:0] STARVE_LIM = SCW'(STARVE_MAX);

    logic [SCW-1:0]  starve_cnt;
    logic            force1;
    logic            acc0;
    logic            acc1;
    logic [AW-1:0]   sel_addr;
    logic [XLEN-1:0] sel_data;

    // The two accept terms are mutually exclusive by construction of the ready equations.
    always_comb begin
        force1    = wb1_valid && (starve_cnt == STARVE_LIM);
        wb0_ready = ~force1;
        wb1_ready = ~wb0_valid | force1;
        acc0      = wb0_valid & wb0_ready;
        acc1      = wb1_valid & wb1_ready;
        sel_addr  = acc1 ? wb1_addr : wb0_addr;
        sel_data  = acc1 ? wb1_data : wb0_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (wb1_valid && !acc1) begin
            if (starve_cnt != STARVE_LIM) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end else begin
            starve_cnt <= '0;
        end
    end

    // A3/WD3/wb_src hold across idle cycles; only WE3 is cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            WE3    <= 1'b0;
            A3     <= '0;
            WD3    <= '0;
            wb_src <= 1'b0;
        end else if (acc0 || acc1) begin
            WE3    <= (sel_addr != '0);
            A3     <= sel_addr;
            WD3    <= sel_data;
            wb_src <= acc1;
        end else begin
            WE3    <= 1'b0;
        end
    end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-port arbiter and sequencer for the 32x32 integer register file (two combinational read ports, one write port written on posedge `clk` when `WE3`=1). Two writeback sources share the single write port: requester 0 is the in-order integer pipeline writeback and requester 1 is the multi-cycle FP/int-result path (FPU compare/convert/move-to-int, divider). The block grants one request per cycle, registers the winning write onto `WE3`/`A3`/`WD3`, suppresses writes to x0, and prevents requester 1 from starving.

## Interface
- `XLEN`, 32, data width
- `AW`, 5, register address width
- `STARVE_MAX`, 3, consecutive cycles requester 1 may lose arbitration before it is force-granted (>=1)
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `wb0_valid`  in  1  requester 0 has a write pending
- `wb0_addr`  in  AW  requester 0 destination register
- `wb0_data`  in  XLEN  requester 0 write data
- `wb0_ready`  out  1  requester 0 accepted this cycle (combinational)
- `wb1_valid`  in  1  requester 1 has a write pending
- `wb1_addr`  in  AW  requester 1 destination register
- `wb1_data`  in  XLEN  requester 1 write data
- `wb1_ready`  out  1  requester 1 accepted this cycle (combinational)
- `WE3`  out  1  register-file write enable (registered)
- `A3`  out  AW  register-file write address (registered)
- `WD3`  out  XLEN  register-file write data (registered)
- `wb_src`  out  1  source of the current `WE3` write: 0 = requester 0, 1 = requester 1 (registered)

## Operation
- Handshake: transfer on requester k when `wbk_valid & wbk_ready`. Requester must hold valid/addr/data stable until accepted; ready may rise without valid.
- `force1 = wb1_valid & (starve_cnt == STARVE_MAX)`.
- `wb0_ready = ~force1`; `wb1_ready = ~wb0_valid | force1`. At most one transfer per cycle; never both.
- Grant priority: requester 0 by default; requester 1 when requester 0 idle or `force1`.
- Starve counter `starve_cnt`, width clog2(STARVE_MAX+1):
  - `wb1_valid` and not accepted -> increment, saturating at STARVE_MAX.
  - requester 1 accepted, or `wb1_valid`=0 -> clear to 0.
- Output register, loaded every cycle:
  - transfer on k -> `A3`=addr, `WD3`=data, `wb_src`=k, `WE3` = (addr != 0).
  - no transfer -> `WE3`=0; `A3`, `WD3`, `wb_src` hold previous values.
- x0 writes are accepted (ready asserted, handshake completes) but never produce `WE3`=1.
- No reordering within a requester; each requester's writes reach the register file in acceptance order.

## Timing
- Reset (`rst`=1 at edge): `WE3`=0, `A3`=0, `WD3`=0, `wb_src`=0, `starve_cnt`=0. Ready outputs are combinational from inputs and state; during reset cycles they follow the rules above with `starve_cnt`=0, but any transfer in a reset cycle is discarded (no write issued).
- Latency: request accepted in cycle N -> `WE3`/`A3`/`WD3` valid in cycle N+1 -> register file updated at end of N+1; readable on `RD1`/`RD2` from cycle N+2.
- Throughput: one write per cycle, back-to-back, no bubbles.
- Worst-case requester-1 wait with requester 0 continuously valid: STARVE_MAX cycles, accepted on cycle STARVE_MAX+1 of assertion.
- Reset mid-operation: pending `WE3`=1 from the previous cycle still occurs in the reset cycle (register already loaded); the cycle after reset, `WE3`=0. Requesters must re-present unaccepted requests.
- Simultaneous same-address requests: the write accepted later lands later; no merging.

## Test plan
- Reset: assert `rst` 2 cycles with both valids high -> `WE3`=0, `A3`=0, `WD3`=0 on the cycle after reset; no register-file write.
- Single writes: wb0 (x5, 0xDEADBEEF) in cycle 10 -> `WE3`=1, `A3`=5, `WD3`=0xDEADBEEF, `wb_src`=0 in cycle 11; RD1 with A1=5 returns 0xDEADBEEF in cycle 12.
- Collision: both valid, wb0 x3/0x11, wb1 x4/0x22, `starve_cnt`=0 -> wb0 accepted first (`wb1_ready`=0), then wb1 accepted next cycle after wb0 drops; writes appear in that order.
- Starvation, STARVE_MAX=3: wb0 valid every cycle with new data, wb1 valid from cycle 0 -> `starve_cnt` 1,2,3 after cycles 0-2; cycle 3 `wb1_ready`=1, `wb0_ready`=0; `WE3` with `wb_src`=1 in cycle 4; `starve_cnt`=0 after.
- x0 suppression: wb1 x0/0xFFFFFFFF -> `wb1_ready`=1, next cycle `WE3`=0; RD1 with A1=0 stays 0.
- Reset mid-stream: wb0 streaming x1..x8; assert `rst` in cycle of x4 acceptance -> x3 write occurs, x4 never written, `WE3`=0 the cycle after reset.
